// File: rtl/mem_arbiter.sv
// mem_arbiter: serves the fetch and data ports one transaction at a time on a single variable-latency RAM
module mem_arbiter #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 255,
   parameter logic [DATA_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [DATA_W-1:0] imemload,
   output logic              ihit,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [DATA_W-1:0] dstore,
   output logic [DATA_W-1:0] dmemload,
   output logic              dhit,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [DATA_W-1:0] ramstore,
   input  logic [DATA_W-1:0] ramload,
   input  logic [1:0]        ramstate,
   output logic              mem_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [1:0] ACCESS = 2'b10;
   localparam logic [1:0] ERROR  = 2'b11;
   typedef enum logic [1:0] {IDLE, DATA, INSTR, RESP} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] store_q, store_d, imem_q, imem_d, dmem_q, dmem_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              wr_q, wr_d, served_i_q, served_i_d, last_data_q, last_data_d, err_q, err_d;
   logic              d_pend, busy, fin_ok, fin_err;
   logic [DATA_W-1:0] result;
   assign d_pend  = dREN | dWEN;
   assign busy    = (state_q == DATA) | (state_q == INSTR);
   assign fin_ok  = busy & (ramstate == ACCESS);
   // ACCESS takes priority over a timeout landing in the same cycle
   assign fin_err = busy & ~fin_ok & ((ramstate == ERROR) | (cnt_d == CW'(TIMEOUT)));
   assign result  = fin_ok ? ramload : ERR_WORD;
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      store_d     = store_q;
      wr_d        = wr_q;
      served_i_d  = served_i_q;
      last_data_d = last_data_q;
      imem_d      = imem_q;
      dmem_d      = dmem_q;
      err_d       = err_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: if (iREN | d_pend) begin
            served_i_d = iREN & (~d_pend | last_data_q);
            state_d    = served_i_d ? INSTR : DATA;
            addr_d     = served_i_d ? iaddr : daddr;
            store_d    = dstore;
            wr_d       = ~served_i_d & dWEN;
            cnt_d      = '0;
         end
         DATA, INSTR: begin
            cnt_d = cnt_q + CW'(1);
            if (fin_ok | fin_err) begin
               state_d = RESP;
               imem_d  = (state_q == INSTR) ? result : imem_q;
               dmem_d  = (state_q == DATA && !wr_q) ? result : dmem_q;
               err_d   = err_q | fin_err;
            end
         end
         RESP: begin
            state_d     = IDLE;
            last_data_d = ~served_i_q;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         store_q     <= '0;
         wr_q        <= 1'b0;
         served_i_q  <= 1'b0;
         last_data_q <= 1'b0;
         imem_q      <= '0;
         dmem_q      <= '0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         store_q     <= store_d;
         wr_q        <= wr_d;
         served_i_q  <= served_i_d;
         last_data_q <= last_data_d;
         imem_q      <= imem_d;
         dmem_q      <= dmem_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
      end
   assign ramREN   = (state_q == INSTR) | ((state_q == DATA) & ~wr_q);
   assign ramWEN   = (state_q == DATA) & wr_q;
   assign ramaddr  = busy ? addr_q : '0;
   assign ramstore = busy ? store_q : '0;
   assign ihit     = (state_q == RESP) & served_i_q;
   assign dhit     = (state_q == RESP) & ~served_i_q;
   assign imemload = imem_q;
   assign dmemload = dmem_q;
   assign mem_err  = err_q;
endmodule
